// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t       : FSM state encoding (RUN, MD_WAIT, MD_DONE)
//   DEF_*         : default (no-hazard) values of the control outputs
//   MD_CNT_W      : width of the mul/div latency down-counter (MD_LAT <= 255)
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam int MD_CNT_W = 8;

  localparam logic DEF_PC_WR        = 1'b1;
  localparam logic DEF_IFID_WR      = 1'b1;
  localparam logic DEF_IFID_FLUSH   = 1'b0;
  localparam logic DEF_IDEX_WR      = 1'b1;
  localparam logic DEF_IDEX_BUBBLE  = 1'b0;
  localparam logic DEF_EXMEM_BUBBLE = 1'b0;
  localparam logic DEF_MD_START     = 1'b0;
  localparam logic DEF_MD_BUSY      = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value.
//   clk   : clock
//   clear : synchronous clear, takes priority over inc
//   inc   : count enable
//   count : current value, W bits
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall/flush controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes in ID, and sequencing of the multi-cycle mul/div unit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal operation; md > lu > br hazard priority
// MD_WAIT | mul/div running, pipeline held, EX/MEM bubbled
// MD_DONE | one cycle, finished mul/div leaves EX; lu/br apply normally
//
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   ID_RS/RT_addr_i, ID_uses_RT_i, ID_branch_taken_i : ID stage info
//   EX_MemRd_i, EX_RT_addr_i, EX_md_req_i             : EX stage info
//   PC_wr_o, IFID_wr_o, IFID_flush_o, IDEX_wr_o, IDEX_bubble_o,
//   EXMEM_bubble_o              : pipeline register controls (combinational)
//   md_start_o, md_busy_o       : mul/div start pulse and busy flag
//   stall_cnt_o                 : saturating count of cycles with PC_wr_o=0
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS_addr_i,
  input  logic [4:0]       ID_RT_addr_i,
  input  logic             ID_uses_RT_i,
  input  logic             ID_branch_taken_i,
  input  logic             EX_MemRd_i,
  input  logic [4:0]       EX_RT_addr_i,
  input  logic             EX_md_req_i,
  output logic             PC_wr_o,
  output logic             IFID_wr_o,
  output logic             IFID_flush_o,
  output logic             IDEX_wr_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_bubble_o,
  output logic             md_start_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

  state_t              state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                lu_hzd;
  logic                md_hzd;

  // $zero is never a real dependency; rt only counts when ID reads it.
  assign lu_hzd = EX_MemRd_i && (EX_RT_addr_i != 5'd0) &&
                  ((EX_RT_addr_i == ID_RS_addr_i) ||
                   (ID_uses_RT_i && (EX_RT_addr_i == ID_RT_addr_i)));

  // In MD_DONE the finished mul/div is still in EX, so its request is ignored.
  assign md_hzd = (state_q == RUN) && EX_md_req_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    PC_wr_o        = DEF_PC_WR;
    IFID_wr_o      = DEF_IFID_WR;
    IFID_flush_o   = DEF_IFID_FLUSH;
    IDEX_wr_o      = DEF_IDEX_WR;
    IDEX_bubble_o  = DEF_IDEX_BUBBLE;
    EXMEM_bubble_o = DEF_EXMEM_BUBBLE;
    md_start_o     = DEF_MD_START;
    md_busy_o      = DEF_MD_BUSY;

    if (!rst_i) begin
      unique case (state_q)
        RUN, MD_DONE: begin
          if (state_q == MD_DONE) state_d = RUN;
          if (md_hzd) begin
            md_start_o     = 1'b1;
            PC_wr_o        = 1'b0;
            IFID_wr_o      = 1'b0;
            IDEX_wr_o      = 1'b0;
            EXMEM_bubble_o = 1'b1;
            cnt_d          = MD_LOAD;
            state_d        = MD_WAIT;
          end else if (lu_hzd) begin
            PC_wr_o       = 1'b0;
            IFID_wr_o     = 1'b0;
            IDEX_bubble_o = 1'b1;
          end else if (ID_branch_taken_i) begin
            // A branch frozen in ID during mul/div lands here in MD_DONE.
            IFID_flush_o = 1'b1;
          end
        end
        MD_WAIT: begin
          PC_wr_o        = 1'b0;
          IFID_wr_o      = 1'b0;
          IDEX_wr_o      = 1'b0;
          EXMEM_bubble_o = 1'b1;
          md_busy_o      = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = MD_DONE;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .inc   (!PC_wr_o),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // control vector packing: {PC_wr, IFID_wr, IFID_flush, IDEX_wr,
  //                          IDEX_bubble, EXMEM_bubble, md_start, md_busy}
  localparam logic [7:0] C_DEF   = 8'b1101_0000;
  localparam logic [7:0] C_LU    = 8'b0001_1000;
  localparam logic [7:0] C_BR    = 8'b1111_0000;
  localparam logic [7:0] C_START = 8'b0000_0110;
  localparam logic [7:0] C_WAIT  = 8'b0000_0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_br, ex_memrd, ex_md;

  logic        pc_wr_a, ifid_wr_a, ifid_flush_a, idex_wr_a, idex_bub_a, exmem_bub_a, start_a, busy_a;
  logic [15:0] cnt_a;
  logic        pc_wr_b, ifid_wr_b, ifid_flush_b, idex_wr_b, idex_bub_b, exmem_bub_b, start_b, busy_b;
  logic [2:0]  cnt_b;
  logic [7:0]  ctl_a, ctl_b;

  assign ctl_a = {pc_wr_a, ifid_wr_a, ifid_flush_a, idex_wr_a, idex_bub_a, exmem_bub_a, start_a, busy_a};
  assign ctl_b = {pc_wr_b, ifid_wr_b, ifid_flush_b, idex_wr_b, idex_bub_b, exmem_bub_b, start_b, busy_b};

  hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .ID_RS_addr_i(id_rs), .ID_RT_addr_i(id_rt), .ID_uses_RT_i(id_uses_rt),
    .ID_branch_taken_i(id_br), .EX_MemRd_i(ex_memrd), .EX_RT_addr_i(ex_rt),
    .EX_md_req_i(ex_md),
    .PC_wr_o(pc_wr_a), .IFID_wr_o(ifid_wr_a), .IFID_flush_o(ifid_flush_a),
    .IDEX_wr_o(idex_wr_a), .IDEX_bubble_o(idex_bub_a), .EXMEM_bubble_o(exmem_bub_a),
    .md_start_o(start_a), .md_busy_o(busy_a), .stall_cnt_o(cnt_a)
  );

  hazard_ctrl #(.MD_LAT(1), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .ID_RS_addr_i(id_rs), .ID_RT_addr_i(id_rt), .ID_uses_RT_i(id_uses_rt),
    .ID_branch_taken_i(id_br), .EX_MemRd_i(ex_memrd), .EX_RT_addr_i(ex_rt),
    .EX_md_req_i(ex_md),
    .PC_wr_o(pc_wr_b), .IFID_wr_o(ifid_wr_b), .IFID_flush_o(ifid_flush_b),
    .IDEX_wr_o(idex_wr_b), .IDEX_bubble_o(idex_bub_b), .EXMEM_bubble_o(exmem_bub_b),
    .md_start_o(start_b), .md_busy_o(busy_b), .stall_cnt_o(cnt_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic br, input logic memrd, input logic [4:0] xrt,
                       input logic md);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; id_br = br;
    ex_memrd = memrd; ex_rt = xrt; ex_md = md;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk8("reset_ctl_a", ctl_a, C_DEF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk8("post_reset_ctl_a", ctl_a, C_DEF);
    chk_cnt("post_reset_cnt_a", int'(cnt_a), 0);
    chk_cnt("post_reset_cnt_b", int'(cnt_b), 0);
  endtask

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       memrd;
    logic [4:0] xrt;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] e;
  int exp_cnt;

  initial begin
    tbl[0] = '{5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  C_DEF};  // idle
    tbl[1] = '{5'd5,  5'd0, 1'b0, 1'b0, 1'b1, 5'd5,  C_LU};   // load-use on rs
    tbl[2] = '{5'd0,  5'd0, 1'b1, 1'b0, 1'b1, 5'd0,  C_DEF};  // $zero
    tbl[3] = '{5'd3,  5'd7, 1'b0, 1'b0, 1'b1, 5'd7,  C_DEF};  // rt unused
    tbl[4] = '{5'd3,  5'd7, 1'b1, 1'b0, 1'b1, 5'd7,  C_LU};   // load-use on rt
    tbl[5] = '{5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 5'd5,  C_DEF};  // not a load
    tbl[6] = '{5'd1,  5'd2, 1'b1, 1'b1, 1'b0, 5'd0,  C_BR};   // branch flush
    tbl[7] = '{5'd9,  5'd2, 1'b1, 1'b1, 1'b1, 5'd9,  C_LU};   // lu beats br
    tbl[8] = '{5'd9,  5'd2, 1'b1, 1'b1, 1'b0, 5'd9,  C_BR};   // branch next cycle
    tbl[9] = '{5'd31, 5'd4, 1'b0, 1'b0, 1'b1, 5'd31, C_LU};   // top register

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Single-cycle hazards in RUN, checked on both instances.
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].br, tbl[i].memrd, tbl[i].xrt, 1'b0);
      #1;
      chk8($sformatf("vec%0d_a", i), ctl_a, tbl[i].exp);
      chk8($sformatf("vec%0d_b", i), ctl_b, tbl[i].exp);
      if (tbl[i].exp[7] == 1'b0) exp_cnt++;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt("vec_stall_cnt_a", int'(cnt_a), exp_cnt);

    // Mul/div with request held: A (MD_LAT=4) runs once, B (MD_LAT=1) twice.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 1'b1);
      #1;
      e = (c == 0) ? C_START : (c <= 4) ? C_WAIT : C_DEF;
      chk8($sformatf("md_a_c%0d", c), ctl_a, e);
      e = (c == 0 || c == 3) ? C_START : (c == 1 || c == 4) ? C_WAIT : C_DEF;
      chk8($sformatf("md_b_c%0d", c), ctl_b, e);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk8("md_after_a", ctl_a, C_DEF);
    chk_cnt("md_stall_cnt_a", int'(cnt_a), 5);
    chk_cnt("md_stall_cnt_b", int'(cnt_b), 4);

    // Branch deferred behind mul/div: flush only in MD_DONE.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 1'b1, 0, 0, 1'b1);
      #1;
      e = (c == 0) ? C_START : (c <= 4) ? C_WAIT : C_BR;
      chk8($sformatf("mdbr_a_c%0d", c), ctl_a, e);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk8("mdbr_after_a", ctl_a, C_DEF);

    // Reset in the 2nd MD_WAIT cycle abandons the operation.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 1'b1);
      if (c == 2) rst = 1'b1;
      #1;
      e = (c == 0) ? C_START : (c == 1) ? C_WAIT : C_DEF;
      chk8($sformatf("mdrst_a_c%0d", c), ctl_a, e);
    end
    chk8("mdrst_b_in_reset", ctl_b, C_DEF);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk8("mdrst_after_a", ctl_a, C_DEF);
    chk_cnt("mdrst_cnt_a", int'(cnt_a), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1'b1);
    #1;
    chk8("mdrst_restart_a", ctl_a, C_START);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk8("mdrst_reset2_a", ctl_a, C_DEF);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: 10 load-use stalls; B's 3-bit counter sticks at 7.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(5'd6, 0, 0, 0, 1'b1, 5'd6, 0);
      #1;
      chk_cnt($sformatf("sat_b_c%0d", c), int'(cnt_b), (c < 7) ? c : 7);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt("sat_final_a", int'(cnt_a), 10);
    chk_cnt("sat_final_b", int'(cnt_b), 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
